// File: rtl/class_op_arb.sv
// class_op_arb: arbitrates lookup/insert/remove requests onto a single-outstanding engine.
// Optional WAIT timeout is built only when CLASS_OP_ARB_TIMEOUT_EN is defined.
module class_op_arb #(
    parameter int BUS_WIDTH = 128,
    parameter int ITEMS = 32768,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT = 1024,
    localparam int VT_AWIDTH = $clog2(ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lu_vld,
    input  logic                 ins_vld,
    input  logic                 rm_vld,
    input  logic [BUS_WIDTH-1:0] lu_key,
    input  logic [BUS_WIDTH-1:0] ins_key,
    input  logic [BUS_WIDTH-1:0] rm_key,
    output logic                 lu_rdy,
    output logic                 ins_rdy,
    output logic                 rm_rdy,
    output logic                 lu_done,
    output logic                 ins_done,
    output logic                 rm_done,
    output logic                 res_hit_miss,
    output logic [VT_AWIDTH-1:0] res_vid,
    output logic                 res_err,
    output logic                 eng_vld,
    output logic [1:0]           eng_op,
    output logic [BUS_WIDTH-1:0] eng_key,
    input  logic                 eng_done,
    input  logic                 eng_hit_miss,
    input  logic [VT_AWIDTH-1:0] eng_vid,
    input  logic                 eng_err,
    output logic                 busy,
    output logic                 spurious
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    state_t state, nxt;
    logic [7:0] starve;
    logic [1:0] op;
    logic [BUS_WIDTH-1:0] key;
    logic rr, pend, lu_g, ir_g, pick_rm, in_flight, take, tmo;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("class_op_arb: parameter out of legal range");
    end

    // Lookups win unless insert/remove work has been starved for STARVE_LIMIT grants.
    assign pend = ins_vld | rm_vld;
    assign lu_g = !rst && state == IDLE && lu_vld && !(pend && starve == LIMIT);
    assign ir_g = !rst && state == IDLE && pend && !lu_g;
    assign pick_rm = rm_vld && (!ins_vld || rr);
    assign lu_rdy = lu_g;
    assign ins_rdy = ir_g && !pick_rm;
    assign rm_rdy = ir_g && pick_rm;
    assign in_flight = state == ISSUE || state == WAIT;
    assign take = in_flight && eng_done;
    assign busy = !rst && state != IDLE;
    assign eng_vld = !rst && state == ISSUE;
    assign eng_op = op;
    assign eng_key = key;
    assign lu_done = !rst && state == RESP && op == 2'd0;
    assign ins_done = !rst && state == RESP && op == 2'd1;
    assign rm_done = !rst && state == RESP && op == 2'd2;

`ifdef CLASS_OP_ARB_TIMEOUT_EN
    logic [15:0] tcnt;
    assign tmo = state == WAIT && !eng_done && tcnt == 16'(TIMEOUT - 1);
    always_ff @(posedge clk)
        if (rst || state != WAIT || eng_done) tcnt <= '0;
        else tcnt <= tcnt + 16'd1;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (lu_g || ir_g) ? ISSUE : IDLE;
            ISSUE:   nxt = eng_done ? RESP : WAIT;
            WAIT:    nxt = (eng_done || tmo) ? RESP : WAIT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            starve <= '0;
            rr <= 1'b0;
            spurious <= 1'b0;
            op <= '0;
            key <= '0;
            res_hit_miss <= 1'b0;
            res_vid <= '0;
            res_err <= 1'b0;
        end else begin
            state <= nxt;
            if (lu_g || ir_g) begin
                op <= lu_g ? 2'd0 : pick_rm ? 2'd2 : 2'd1;
                key <= lu_g ? lu_key : pick_rm ? rm_key : ins_key;
            end
            if (!pend || ir_g) starve <= '0;
            else if (lu_g && starve != LIMIT) starve <= starve + 8'd1;
            if (ir_g) rr <= !rr;
            if (eng_done && !in_flight) spurious <= 1'b1;
            if (take) begin
                res_hit_miss <= eng_hit_miss;
                res_vid <= eng_vid;
                res_err <= eng_err;
            end else if (tmo) begin
                res_hit_miss <= 1'b0;
                res_vid <= '0;
                res_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_class_op_arb.sv
// tb_class_op_arb: randomized scoreboard bench for class_op_arb against a transaction-level
// arbitration model; adds a timeout scenario when CLASS_OP_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_class_op_arb;
    localparam int BW = 32, VW = 15, SL = 8, TO = 16;
    localparam int NEVER = 1 << 30;
`ifdef CLASS_OP_ARB_TIMEOUT_EN
    localparam int TMO_PH = TO + 2;
`else
    localparam int TMO_PH = NEVER;
`endif

    logic clk = 0, rst = 1;
    logic lu_vld = 0, ins_vld = 0, rm_vld = 0;
    logic [BW-1:0] lu_key = 0, ins_key = 0, rm_key = 0;
    logic lu_rdy, ins_rdy, rm_rdy, lu_done, ins_done, rm_done;
    logic res_hit_miss, res_err, eng_vld, busy, spurious;
    logic [VW-1:0] res_vid;
    logic [1:0] eng_op;
    logic [BW-1:0] eng_key;
    logic eng_done = 0, eng_hit_miss = 0, eng_err = 0;
    logic [VW-1:0] eng_vid = 0;

    class_op_arb #(.BUS_WIDTH(BW), .ITEMS(32768), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .lu_vld(lu_vld), .ins_vld(ins_vld), .rm_vld(rm_vld),
        .lu_key(lu_key), .ins_key(ins_key), .rm_key(rm_key),
        .lu_rdy(lu_rdy), .ins_rdy(ins_rdy), .rm_rdy(rm_rdy),
        .lu_done(lu_done), .ins_done(ins_done), .rm_done(rm_done),
        .res_hit_miss(res_hit_miss), .res_vid(res_vid), .res_err(res_err),
        .eng_vld(eng_vld), .eng_op(eng_op), .eng_key(eng_key),
        .eng_done(eng_done), .eng_hit_miss(eng_hit_miss), .eng_vid(eng_vid), .eng_err(eng_err),
        .busy(busy), .spurious(spurious)
    );

    always #5 clk = ~clk;

    typedef struct {int own; logic hit; logic [VW-1:0] vid; logic err; int cyc;} exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0, cyc = 0;
    int ph = -1, resp_ph = 0, eng_n = 0, starve = 0;
    logic rr = 0, spur_m = 0, m_hit = 0, m_err = 0, c_hit = 0, c_err = 0;
    logic [VW-1:0] m_vid = 0, c_vid = 0;
    logic [1:0] m_op = 0;
    logic [BW-1:0] m_key = 0;
    logic silent = 0, inj = 0, dir = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: ph counts cycles since grant (1 = issue), -1 when the arbiter is free.
    always @(negedge clk) begin
        int g, rdy_exp;
        logic pend;
        exp_t e;
        pend = ins_vld | rm_vld;
        g = 0;
        if (!rst && ph < 0 && (lu_vld || pend))
            g = (lu_vld && !(pend && starve == SL)) ? 1 : (ins_vld && rm_vld) ? (rr ? 3 : 2) : (ins_vld ? 2 : 3);
        rdy_exp = g == 1 ? 4 : g == 2 ? 2 : g == 3 ? 1 : 0;
        chk("rdy", 64'({lu_rdy, ins_rdy, rm_rdy}), 64'(rdy_exp));
        chk("busy", 64'(busy), 64'(!rst && ph >= 1));
        chk("eng_vld", 64'(eng_vld), 64'(!rst && ph == 1));
        chk("eng_op", 64'(eng_op), 64'(m_op));
        chk("eng_key", 64'(eng_key), 64'(m_key));
        chk("spurious", 64'(spurious), 64'(spur_m));
        chk("res_hold", 64'({res_hit_miss, res_vid, res_err}), 64'({m_hit, m_vid, m_err}));
        if (rst) begin
            ph = -1; starve = 0; rr = 0; spur_m = 0;
            m_hit = 0; m_vid = 0; m_err = 0; m_op = 0; m_key = 0;
            sb.delete();
            eng_done = 0;
        end else begin
            eng_done = inj || (ph >= 1 && ph == eng_n);
            eng_hit_miss = c_hit; eng_vid = c_vid; eng_err = c_err;
            if (inj && !(ph >= 1 && ph < resp_ph)) spur_m = 1;
            if (ph >= 1 && ph == resp_ph - 1) begin m_hit = c_hit; m_vid = c_vid; m_err = c_err; end
            if (ph >= 1) ph = (ph == resp_ph) ? -1 : ph + 1;
            if (g != 0) begin
                if (g == 1 && pend && starve < SL) starve++;
                if (g > 1) begin starve = 0; rr = !rr; end
                m_op = g == 1 ? 2'd0 : g == 2 ? 2'd1 : 2'd2;
                m_key = g == 1 ? lu_key : g == 2 ? ins_key : rm_key;
                eng_n = silent ? NEVER : dir ? 3 : int'($urandom_range(1, 6));
                resp_ph = silent ? TMO_PH : eng_n + 1;
                c_hit = silent ? 1'b0 : dir ? 1'b1 : 1'($urandom);
                c_vid = silent ? '0 : dir ? VW'(5) : VW'($urandom);
                c_err = silent ? 1'b1 : dir ? 1'b0 : 1'($urandom);
                e.own = g; e.hit = c_hit; e.vid = c_vid; e.err = c_err; e.cyc = cyc + resp_ph;
                sb.push_back(e);
                ph = 1;
            end
            if (!pend) starve = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) chk("done_in_rst", 64'({lu_done, ins_done, rm_done}), 64'(0));
        else if (lu_done || ins_done || rm_done) begin
            if (sb.size() == 0) chk("unexpected_done", 64'({lu_done, ins_done, rm_done}), 64'(0));
            else begin
                e = sb.pop_front();
                chk("done_owner", 64'({lu_done, ins_done, rm_done}), 64'(e.own == 1 ? 4 : e.own == 2 ? 2 : 1));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("done_res", 64'({res_hit_miss, res_vid, res_err}), 64'({e.hit, e.vid, e.err}));
            end
        end
    end

    initial begin
        step(3);
        rst = 0;
        dir = 1; lu_vld = 1; lu_key = 32'h1234;
        step(1);
        lu_vld = 0; dir = 0;
        step(8);
        lu_vld = 1; ins_vld = 1;
        repeat (200) begin lu_key = $urandom; ins_key = $urandom; step(1); end
        lu_vld = 0; ins_vld = 0;
        step(10);
        ins_vld = 1; rm_vld = 1;
        repeat (100) begin ins_key = $urandom; rm_key = $urandom; step(1); end
        ins_vld = 0; rm_vld = 0;
        step(10);
        repeat (1500) begin
            {lu_vld, ins_vld, rm_vld} = 3'($urandom);
            lu_key = $urandom; ins_key = $urandom; rm_key = $urandom;
            step(1);
        end
        {lu_vld, ins_vld, rm_vld} = 3'b000;
        step(10);
        inj = 1; step(1); inj = 0;
        step(3);
        rst = 1; step(2); rst = 0;
        silent = 1; lu_vld = 1; lu_key = $urandom;
        step(1);
        lu_vld = 0;
        step(3);
        rst = 1; step(2); rst = 0;
        silent = 0;
        step(2);
        inj = 1; step(1); inj = 0;
        step(3);
`ifdef CLASS_OP_ARB_TIMEOUT_EN
        rst = 1; step(2); rst = 0;
        silent = 1; rm_vld = 1; rm_key = $urandom;
        step(1);
        rm_vld = 0;
        step(TO + 6);
        silent = 0;
        inj = 1; step(1); inj = 0;
        step(3);
`endif
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
